// File: rtl/alu_pkg.sv
// Shared constants, opcode encodings, state enum and command
// record for the ALU command sequencer.
package alu_pkg;

    localparam logic [2:0] IN_SEL_PERSIST = 3'b100;
    localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
    localparam logic [2:0] IN_SEL_RESET   = 3'b001;

    localparam logic [6:0] OP_ADD = 7'b1000000;
    localparam logic [6:0] OP_SUB = 7'b0100000;
    localparam logic [6:0] OP_AND = 7'b0010000;
    localparam logic [6:0] OP_OR  = 7'b0001000;
    localparam logic [6:0] OP_XOR = 7'b0000100;
    localparam logic [6:0] OP_NOT = 7'b0000010;
    localparam logic [6:0] OP_SHL = 7'b0000001;

    typedef enum logic [2:0] {
        ST_CLR,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } seq_state_t;

    typedef struct packed {
        logic [7:0] num1;
        logic [7:0] num2;
        logic [6:0] op;
    } alu_cmd_t;

    function automatic logic is_onehot7(
        input logic [6:0] v
    );
        return (v != 7'd0) &&
               ((v & (v - 7'd1)) == 7'd0);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-drive and result channels of the sequencer.
// slave = sequencer side, master = producer/ALU/consumer side.
interface alu_op_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_num1;
    logic [7:0] cmd_num2;
    logic [6:0] cmd_op;

    logic [2:0] alu_in_sel;
    logic [7:0] alu_num1;
    logic [7:0] alu_num2;
    logic [6:0] alu_out_sel;
    logic [7:0] alu_out;

    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [6:0] res_op;

    modport slave (
        input  cmd_valid, cmd_num1, cmd_num2, cmd_op,
        input  alu_out, res_ready,
        output cmd_ready,
        output alu_in_sel, alu_num1, alu_num2, alu_out_sel,
        output res_valid, res_data, res_op
    );

    modport master (
        output cmd_valid, cmd_num1, cmd_num2, cmd_op,
        output alu_out, res_ready,
        input  cmd_ready,
        input  alu_in_sel, alu_num1, alu_num2, alu_out_sel,
        input  res_valid, res_data, res_op
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Small synchronous FIFO for queued ALU commands.
// Pointers wrap modulo DEPTH (power of two).
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [W-1:0]           i_data,
    output logic [W-1:0]           o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full && !rst;
    assign w_pop   = i_pop && !o_empty && !rst;

    // Storage write; no reset needed on the data array.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= i_data;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands and issues them one at a time to the ALU.
// Optional opcode check: define ALU_SEQ_OPCHK_EN.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   on,
    alu_op_sequencer_if.slave      bus,
    output logic                   err,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int CW =
        (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    seq_state_t    r_state;
    logic [2:0]    r_in_sel;
    logic [7:0]    r_num1;
    logic [7:0]    r_num2;
    logic [6:0]    r_out_sel;
    logic          r_res_valid;
    logic [7:0]    r_res_data;
    logic [6:0]    r_res_op;
    logic [CW-1:0] r_wcnt;

    alu_cmd_t w_cmd_in;
    alu_cmd_t w_head;
    logic     w_full;
    logic     w_empty;
    logic     w_accept;
    logic     w_push;
    logic     w_pop;

    assign w_cmd_in = '{num1: bus.cmd_num1,
                        num2: bus.cmd_num2,
                        op:   bus.cmd_op};

    assign bus.cmd_ready = !w_full;
    assign w_accept = bus.cmd_valid && !w_full && !rst;

`ifdef ALU_SEQ_OPCHK_EN
    logic w_bad;
    logic r_err;

    assign w_bad  = !is_onehot7(bus.cmd_op);
    assign w_push = w_accept && !w_bad;
    assign err    = r_err;

    // Sticky flag for dropped non-one-hot opcodes.
    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_accept && w_bad)
            r_err <= 1'b1;
    end
`else
    assign w_push = w_accept;
    assign err    = 1'b0;
`endif

    // Pop only when the FSM is free to start a new command.
    assign w_pop = !rst && on && !w_empty &&
                   ((r_state == ST_IDLE) ||
                    (r_state == ST_HOLD && bus.res_ready));

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(alu_cmd_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_cmd_in),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    // Issue FSM with registered ALU drive and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_CLR;
            r_in_sel    <= IN_SEL_RESET;
            r_num1      <= '0;
            r_num2      <= '0;
            r_out_sel   <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_op    <= '0;
            r_wcnt      <= '0;
        end else begin
            unique case (r_state)
                ST_CLR: begin
                    r_in_sel <= IN_SEL_PERSIST;
                    r_state  <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (w_pop) begin
                        r_num1    <= w_head.num1;
                        r_num2    <= w_head.num2;
                        r_out_sel <= w_head.op;
                        r_in_sel  <= IN_SEL_LOAD;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_in_sel <= IN_SEL_PERSIST;
                    r_wcnt   <= CW'(ALU_LAT - 1);
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wcnt == '0) begin
                        r_res_data  <= bus.alu_out;
                        r_res_op    <= r_out_sel;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        if (w_pop) begin
                            r_num1    <= w_head.num1;
                            r_num2    <= w_head.num2;
                            r_out_sel <= w_head.op;
                            r_in_sel  <= IN_SEL_LOAD;
                            r_state   <= ST_ISSUE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_in_sel <= IN_SEL_RESET;
                    r_state  <= ST_CLR;
                end
            endcase
        end
    end

    assign bus.alu_in_sel  = r_in_sel;
    assign bus.alu_num1    = r_num1;
    assign bus.alu_num2    = r_num2;
    assign bus.alu_out_sel = r_out_sel;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_data    = r_res_data;
    assign bus.res_op      = r_res_op;

endmodule
